// File: rtl/mm_pkg.sv
// Shared types and default sizes for the matrix-multiply operand read path.
package mm_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  localparam int MM_N      = 4;
  localparam int MM_ADDR_W = 12;
  localparam int MM_PASS_W = 8;
endpackage

// File: rtl/mm_rd_seq.sv
// Read sequencer: walks an address window for a number of passes, then waits
// out the bank skew of the downstream skewed read stage before pulsing done.
module mm_rd_seq
  import mm_pkg::*;
#(
  parameter int N      = MM_N,
  parameter int ADDR_W = MM_ADDR_W,
  parameter int PASS_W = MM_PASS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] len,
  input  logic [PASS_W-1:0] passes,
  input  logic              stall,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [PASS_W-1:0] pass_idx,
  output logic              busy,
  output logic              done
);

  localparam int             DW    = (N > 1) ? $clog2(N) : 1;
  // state_q leads the registered outputs by one cycle, so the drain wait also
  // covers the cycle that still shows the final address: N cycles total.
  localparam logic [DW-1:0]  DLAST = DW'(N - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d, len_q, len_d, cnt_q, cnt_d;
  logic [PASS_W-1:0]   passes_q, passes_d, pcnt_q, pcnt_d;
  logic [DW-1:0]       dcnt_q, dcnt_d;
  logic                rd_en_q, rd_en_d, busy_q, busy_d, done_q, done_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [PASS_W-1:0]   pass_idx_q, pass_idx_d;

  logic                accept, zero_job, issue, last_addr, last_issue;
  logic [ADDR_W-1:0]   cur_base, cur_len, cur_cnt;
  logic [PASS_W-1:0]   cur_passes, cur_pass;

  // The accepting IDLE edge issues the first address straight from the inputs.
  always_comb begin
    accept     = (state_q == IDLE) && start;
    zero_job   = (len == '0) || (passes == '0);
    cur_base   = accept ? base_addr : base_q;
    cur_len    = accept ? len       : len_q;
    cur_passes = accept ? passes    : passes_q;
    cur_cnt    = accept ? '0        : cnt_q;
    cur_pass   = accept ? '0        : pcnt_q;
    last_addr  = (cur_cnt == cur_len - ADDR_W'(1));
    last_issue = last_addr && (cur_pass == cur_passes - PASS_W'(1));
    issue      = (accept && !zero_job) || ((state_q == RUN) && !stall);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      passes_q   <= '0;
      cnt_q      <= '0;
      pcnt_q     <= '0;
      dcnt_q     <= '0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      pass_idx_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      passes_q   <= passes_d;
      cnt_q      <= cnt_d;
      pcnt_q     <= pcnt_d;
      dcnt_q     <= dcnt_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      pass_idx_q <= pass_idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (zero_job)        state_d = FIN;
          else if (last_issue) state_d = DRAIN;
          else                 state_d = RUN;
        end
      end
      RUN:   if (issue && last_issue) state_d = DRAIN;
      DRAIN: if (dcnt_q == DLAST)     state_d = FIN;
      FIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    base_d     = base_q;
    len_d      = len_q;
    passes_d   = passes_q;
    cnt_d      = cnt_q;
    pcnt_d     = pcnt_q;
    rd_addr_d  = rd_addr_q;
    pass_idx_d = pass_idx_q;
    if (accept) begin
      base_d     = base_addr;
      len_d      = len;
      passes_d   = passes;
      cnt_d      = '0;
      pcnt_d     = '0;
      pass_idx_d = '0;
    end
    if (issue) begin
      cnt_d      = last_addr ? '0 : cur_cnt + ADDR_W'(1);
      pcnt_d     = last_addr ? cur_pass + PASS_W'(1) : cur_pass;
      rd_addr_d  = cur_base + cur_cnt;
      pass_idx_d = cur_pass;
    end
    dcnt_d  = (state_q == DRAIN) ? dcnt_q + DW'(1) : '0;
    rd_en_d = issue;
    busy_d  = (state_d == RUN) || (state_d == DRAIN);
    done_d  = (state_d == FIN);
  end

  assign rd_en    = rd_en_q;
  assign rd_addr  = rd_addr_q;
  assign pass_idx = pass_idx_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_mm_rd_seq.sv
// Bench for mm_rd_seq: N=4 and N=1 builds checked cycle by cycle against a
// trace computed from the issue/drain/done timing rules.
module tb_mm_rd_seq;
  localparam int AW = 12;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst, start, start1, stall, stall1;
  logic [AW-1:0] base_addr, len;
  logic [PW-1:0] passes;
  logic          rd_en, busy, done, rd_en1, busy1, done1;
  logic [AW-1:0] rd_addr, rd_addr1;
  logic [PW-1:0] pass_idx, pass_idx1;

  int n_tests = 0;
  int n_fail  = 0;

  // stall_at[e] / restart_at[e]: value presented to the edge ending cycle e
  bit stall_at[256];
  bit restart_at[256];

  always #5 clk = ~clk;

  mm_rd_seq #(.N(4), .ADDR_W(AW), .PASS_W(PW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .passes(passes), .stall(stall), .rd_en(rd_en), .rd_addr(rd_addr),
    .pass_idx(pass_idx), .busy(busy), .done(done));

  mm_rd_seq #(.N(1), .ADDR_W(AW), .PASS_W(PW)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .base_addr(base_addr), .len(len),
    .passes(passes), .stall(stall1), .rd_en(rd_en1), .rd_addr(rd_addr1),
    .pass_idx(pass_idx1), .busy(busy1), .done(done1));

  task automatic clear_pattern();
    for (int i = 0; i < 256; i++) begin
      stall_at[i]   = 1'b0;
      restart_at[i] = 1'b0;
    end
  endtask

  // Issue k of the job is address base + k%len of pass k/len; the first
  // issue lands in cycle 1, later ones in the first cycle whose preceding
  // edge saw no stall. Done follows the final issue by N cycles.
  task automatic run_job(input string name, input bit sel, input logic [AW-1:0] b,
                         input logic [AW-1:0] l, input logic [PW-1:0] p);
    int            nn = sel ? 1 : 4;
    int            ll = int'(l);
    int            lp = int'(l) * int'(p);
    bit            e_en[256];
    logic [AW-1:0] e_addr[256];
    int            e_pidx[256];
    int            k = 0, last_c = 0, done_c, cur_p = 0;
    logic          o_en, o_busy, o_done;
    logic [AW-1:0] o_addr;
    int            o_pidx;
    bit            e_busy, e_done;
    for (int c = 0; c < 256; c++) begin
      e_en[c] = 1'b0; e_addr[c] = '0; e_pidx[c] = 0;
    end
    for (int c = 1; c < 200 && k < lp; c++) begin
      if (c == 1 || !stall_at[c-1]) begin
        e_en[c]   = 1'b1;
        e_addr[c] = AW'(int'(b) + k % ll);
        e_pidx[c] = k / ll;
        k++;
        last_c = c;
      end
    end
    done_c = (lp == 0) ? 1 : last_c + nn;
    for (int c = 1; c <= done_c + 2; c++) begin
      if (e_en[c]) cur_p = e_pidx[c];
      e_pidx[c] = cur_p;
    end

    @(negedge clk);
    base_addr = b; len = l; passes = p;
    if (sel) begin start1 = 1'b1; stall1 = stall_at[0]; end
    else     begin start  = 1'b1; stall  = stall_at[0]; end
    @(posedge clk);
    for (int c = 1; c <= done_c + 2; c++) begin
      @(negedge clk);
      o_en   = sel ? rd_en1    : rd_en;
      o_addr = sel ? rd_addr1  : rd_addr;
      o_pidx = int'(sel ? pass_idx1 : pass_idx);
      o_busy = sel ? busy1     : busy;
      o_done = sel ? done1     : done;
      e_busy = (lp > 0) && (c < done_c);
      e_done = (c == done_c);
      n_tests += 4;
      if (o_en !== e_en[c]) begin
        n_fail++; $display("FAIL %s c%0d rd_en got %0b exp %0b", name, c, o_en, e_en[c]);
      end
      if (o_busy !== e_busy) begin
        n_fail++; $display("FAIL %s c%0d busy got %0b exp %0b", name, c, o_busy, e_busy);
      end
      if (o_done !== e_done) begin
        n_fail++; $display("FAIL %s c%0d done got %0b exp %0b", name, c, o_done, e_done);
      end
      if (o_pidx != e_pidx[c]) begin
        n_fail++; $display("FAIL %s c%0d pass_idx got %0d exp %0d", name, c, o_pidx, e_pidx[c]);
      end
      if (e_en[c]) begin
        n_tests++;
        if (o_addr !== e_addr[c]) begin
          n_fail++; $display("FAIL %s c%0d rd_addr got %h exp %h", name, c, o_addr, e_addr[c]);
        end
      end
      // Starts up to and including the FIN cycle must be ignored.
      if (sel) begin start1 = (c <= done_c) && restart_at[c]; stall1 = stall_at[c]; end
      else     begin start  = (c <= done_c) && restart_at[c]; stall  = stall_at[c]; end
      if (restart_at[c]) begin
        base_addr = AW'($urandom); len = AW'($urandom_range(1, 9)); passes = PW'($urandom_range(1, 4));
      end
      @(posedge clk);
    end
    @(negedge clk);
    start = 1'b0; start1 = 1'b0; stall = 1'b0; stall1 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start1 = 1'b0; stall = 1'b0; stall1 = 1'b0;
    base_addr = '0; len = '0; passes = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({rd_en, rd_addr, pass_idx, busy, done} !== '0) begin
      n_fail++; $display("FAIL reset n4 outputs got %h exp 0", {rd_en, rd_addr, pass_idx, busy, done});
    end
    n_tests++;
    if ({rd_en1, rd_addr1, pass_idx1, busy1, done1} !== '0) begin
      n_fail++; $display("FAIL reset n1 outputs got %h exp 0", {rd_en1, rd_addr1, pass_idx1, busy1, done1});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    clear_pattern();
    run_job("basic", 1'b0, 12'h010, 12'd4, 8'd2);
  endtask

  task automatic test_stall();
    clear_pattern();
    stall_at[2] = 1'b1; stall_at[3] = 1'b1;
    run_job("stall", 1'b0, 12'h010, 12'd4, 8'd2);
    clear_pattern();
    stall_at[7] = 1'b1; stall_at[8] = 1'b1; stall_at[11] = 1'b1;
    run_job("stall_last", 1'b0, 12'h123, 12'd4, 8'd2);
  endtask

  task automatic test_wrap();
    clear_pattern();
    run_job("wrap", 1'b0, 12'hFFE, 12'd4, 8'd1);
  endtask

  task automatic test_zero();
    clear_pattern();
    run_job("zero_len", 1'b0, 12'h055, 12'd0, 8'd5);
    run_job("zero_passes", 1'b0, 12'h055, 12'd3, 8'd0);
    run_job("single", 1'b0, 12'h200, 12'd1, 8'd1);
  endtask

  task automatic test_restart();
    clear_pattern();
    for (int i = 1; i < 12; i++) restart_at[i] = 1'b1;
    run_job("restart", 1'b0, 12'h010, 12'd4, 8'd2);
    clear_pattern();
    run_job("after_fin", 1'b0, 12'h300, 12'd2, 8'd1);
  endtask

  task automatic test_abort();
    clear_pattern();
    @(negedge clk);
    base_addr = 12'h010; len = 12'd4; passes = 8'd2; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (rd_en !== 1'b1 || rd_addr !== 12'h011) begin
      n_fail++; $display("FAIL abort c2 rd_en/addr got %0b/%h exp 1/011", rd_en, rd_addr);
    end
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    n_tests++;
    if ({rd_en, rd_addr, pass_idx, busy, done} !== '0) begin
      n_fail++; $display("FAIL abort c4 outputs got %h exp 0", {rd_en, rd_addr, pass_idx, busy, done});
    end
    for (int c = 5; c < 20; c++) begin
      @(negedge clk);
      n_tests++;
      if (done !== 1'b0 || rd_en !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL abort c%0d done/rd_en/busy got %0b%0b%0b exp 000", c, done, rd_en, busy);
      end
    end
  endtask

  task automatic test_n1();
    clear_pattern();
    run_job("n1_basic", 1'b1, 12'h040, 12'd2, 8'd1);
    clear_pattern();
    stall_at[1] = 1'b1;
    run_job("n1_stall", 1'b1, 12'hFFF, 12'd3, 8'd2);
  endtask

  task automatic test_random();
    for (int j = 0; j < 8; j++) begin
      clear_pattern();
      for (int i = 0; i < 60; i++) begin
        stall_at[i]   = ($urandom_range(0, 3) == 0);
        restart_at[i] = ($urandom_range(0, 4) == 0);
      end
      run_job("random", j[0], AW'($urandom), AW'($urandom_range(0, 6)), PW'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_zero();
    test_restart();
    test_abort();
    test_n1();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mm_rd_seq.md
# mm_rd_seq

Read sequencer for the matrix-multiply operand memories. It sits in front of the N-bank skewed read stage and drives that stage's single address/enable input. On a start pulse it walks a programmed address window for a programmed number of passes, honours a downstream stall, waits for the N-1-cycle bank skew to drain, then pulses done.

## Interface
- N, 4: number of banks / systolic array dimension; sets drain length N-1
- ADDR_W, 12: address width; also width of len
- PASS_W, 8: width of pass count
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle job request; sampled only in IDLE
- base_addr  in  ADDR_W  first address of window; latched on accepted start
- len  in  ADDR_W  addresses per pass; latched on accepted start
- passes  in  PASS_W  number of passes over window; latched on accepted start
- stall  in  1  downstream not ready; freezes issue in RUN only
- rd_en  out  1  read enable to skewed read stage
- rd_addr  out  ADDR_W  read address to skewed read stage
- pass_idx  out  PASS_W  index of pass currently being issued
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle completion pulse

## Operation
- All outputs registered. Reset values: rd_en=0, rd_addr=0, pass_idx=0, busy=0, done=0, state IDLE, counters 0.
- States: IDLE, RUN, DRAIN, FIN.
- IDLE: start=1 latches base_addr/len/passes and clears cnt and pass_idx. If len==0 or passes==0, go to FIN. Otherwise go to RUN.
- RUN, stall=0: rd_en=1, rd_addr=base+cnt (mod 2^ADDR_W; window may wrap past max address).
  - If cnt==len-1, cnt wraps to 0 and pass_idx increments.
  - If that was the last address of the last pass, go to DRAIN. If N==1, go to FIN instead.
- RUN, stall=1: rd_en=0; rd_addr, cnt and pass_idx hold. A stall coinciding with the final address delays that issue.
- DRAIN: rd_en=0 and stall ignored for N-1 cycles (dcnt counts 0..N-2), then go to FIN.
- FIN: done=1 and busy=0 for one cycle, then IDLE. start is ignored in FIN. A new start is accepted in the IDLE cycle after FIN.
- start outside IDLE is ignored. Latched configuration is not disturbed.
- rst has priority over all other inputs in every state. Reset mid-job aborts with no done pulse, and all outputs reach reset values at the next edge.
- pass_idx after the last pass holds passes-1 until the next start.

## Timing
- Start sampled at edge 0. First rd_en=1 in the cycle after edge 0 (cycle 1).
- No stall, job L×P (L,P≥1): rd_en=1 in cycles 1..L·P; busy in cycles 1..L·P+N-1; done in cycle L·P+N.
- Each stalled cycle during RUN adds exactly one cycle to every later event.
- Zero job (len==0 or passes==0): done in cycle 1, rd_en never asserted, busy never asserted.
- Address issued in cycle c reaches bank k in cycle c+k. DRAIN guarantees bank N-1 has issued the final address before done.

## Structure
- Shared package mm_pkg: state enum (IDLE/RUN/DRAIN/FIN), default N/ADDR_W/PASS_W constants.
- No sub-module inside mm_rd_seq; one FSM plus cnt, pass_idx, dcnt counters.
- Natural parent: mm_rd_path, instantiating mm_rd_seq feeding the skewed read stage.

## Test plan
- Reset, then base=0x010, len=4, passes=2, N=4, no stall -> rd_addr 0x010..0x013 twice in cycles 1..8, pass_idx 0→1 at cycle 5, done in cycle 12 only.
- Same job with stall high in cycles 3–4 -> address 0x012 issued in cycle 5, rd_en=0 in cycles 3–4, done in cycle 14.
- base=0xFFE, len=4, passes=1 -> rd_addr 0xFFE, 0xFFF, 0x000, 0x001; done in cycle 8.
- len=0, passes=5 -> done in cycle 1, rd_en never high. Then passes=0, len=3 -> same result.
- start re-pulsed during RUN and DRAIN -> ignored, original sequence unchanged. rst asserted in cycle 3 of a job -> cycle 4 all outputs 0, no done.
- N=1 build, len=2, passes=1 -> rd_en in cycles 1–2, done in cycle 3, no DRAIN cycle.
